fetch_stage: RTL and testbench

Instruction fetch stage for the 16-bit pipelined core, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues single-outstanding read requests on the instruction-memory port, which is shared with DMA. It buffers returned instructions in a small prefetch FIFO and presents the head entry to IF/ID as instruction, current PC and PC+1. Branch/jump redirects flush the FIFO and discard any in-flight response.

---
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage for the 16-bit pipelined core. Owns the
//            fetch PC, issues single-outstanding reads on the instruction
//            port shared with DMA, buffers returned words in a small
//            prefetch FIFO and presents the head entry to the IF/ID register.
//            Redirects flush the FIFO and discard any in-flight response.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter int                   WORD_SIZE  = 16,
   parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
   parameter int                   FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   // instruction memory port (shared with DMA)
   output logic                 i_req,
   output logic [WORD_SIZE-1:0] i_addr,
   input  logic                 i_ack,
   input  logic [WORD_SIZE-1:0] i_data,
   input  logic                 bus_grant,
   // pipeline control
   input  logic                 halt,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   input  logic                 IFIDWrite,
   // head entry towards IF/ID
   output logic                 IF_valid,
   output logic [WORD_SIZE-1:0] IF_instr,
   output logic [WORD_SIZE-1:0] IF_current_pc,
   output logic [WORD_SIZE-1:0] IF_PC_plus_one
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(FIFO_DEPTH - 1);

   // DISCARD is an outstanding request whose response must be dropped
   localparam logic [1:0] c_S_IDLE    = 2'd0;
   localparam logic [1:0] c_S_REQ     = 2'd1;
   localparam logic [1:0] c_S_DISCARD = 2'd2;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]           r_state;
   logic [WORD_SIZE-1:0] r_fetch_pc;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [WORD_SIZE-1:0] r_pc_mem    [FIFO_DEPTH];
   logic [WORD_SIZE-1:0] r_instr_mem [FIFO_DEPTH];

   logic [1:0]           w_state_next;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_issue;
   logic [c_CNT_W-1:0]   w_count_next;
   logic [c_PTR_W-1:0]   w_wr_ptr_inc;
   logic [c_PTR_W-1:0]   w_rd_ptr_inc;
   logic [WORD_SIZE-1:0] w_head_pc;
   logic [WORD_SIZE-1:0] w_head_instr;

   // -------------------------------------------------------------------------
   // Handshake decode
   // -------------------------------------------------------------------------
   // A redirect kills both the FIFO contents and any arriving data, so it
   // suppresses push and pop outright rather than racing with the flush.
   assign w_pop  = IF_valid & IFIDWrite & ~redirect;
   assign w_push = (r_state == c_S_REQ) & i_ack & ~redirect;

   assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

   // Only start a request when its response is guaranteed a slot; this is
   // what keeps a push from ever overflowing the FIFO.
   assign w_issue = bus_grant & ~halt & ~redirect & (w_count_next < c_DEPTH_CNT);

   assign w_wr_ptr_inc = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
   assign w_rd_ptr_inc = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);

   // Next-state logic for the request FSM
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (w_issue) begin
               w_state_next = c_S_REQ;
            end
         end
         c_S_REQ: begin
            if (redirect) begin
               // response already here is simply dropped; otherwise wait it out
               w_state_next = i_ack ? c_S_IDLE : c_S_DISCARD;
            end else if (i_ack) begin
               w_state_next = w_issue ? c_S_REQ : c_S_IDLE;
            end
         end
         c_S_DISCARD: begin
            if (i_ack) begin
               w_state_next = c_S_IDLE;
            end
         end
         default: begin
            w_state_next = c_S_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Fetch PC: reloaded on redirect, advanced on every accepted response
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect) begin
         r_fetch_pc <= redirect_pc;
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + WORD_SIZE'(1);
      end
   end

   // FIFO occupancy and pointers; a redirect empties the FIFO in one cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (redirect) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_count <= w_count_next;
         if (w_push) begin
            r_wr_ptr <= w_wr_ptr_inc;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
      end
   end

   // FIFO storage; contents are only observed through count, so no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
         r_instr_mem[r_wr_ptr] <= i_data;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: all decoded from registers only
   // -------------------------------------------------------------------------
   assign i_req  = (r_state == c_S_REQ) | (r_state == c_S_DISCARD);
   assign i_addr = r_fetch_pc;

   assign w_head_pc    = r_pc_mem[r_rd_ptr];
   assign w_head_instr = r_instr_mem[r_rd_ptr];

   assign IF_valid       = (r_count != '0);
   assign IF_instr       = IF_valid ? w_head_instr : '0;
   assign IF_current_pc  = IF_valid ? w_head_pc : '0;
   assign IF_PC_plus_one = IF_valid ? (w_head_pc + WORD_SIZE'(1)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with a behavioural
//            instruction memory of programmable wait states returning
//            addr ^ 16'hA5A5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_ack  = 1'b0;
   logic [15:0] i_data = '0;
   logic        bus_grant;
   logic        halt;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        IFIDWrite;
   logic        IF_valid;
   logic [15:0] IF_instr;
   logic [15:0] IF_current_pc;
   logic [15:0] IF_PC_plus_one;

   int n_checks = 0;
   int n_errors = 0;

   // memory model state
   int          wait_states = 0;
   int          mem_wait    = 0;
   logic [15:0] req_addr    = '0;

   fetch_stage #(
      .WORD_SIZE  (16),
      .RESET_PC   (16'h0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .i_ack          (i_ack),
      .i_data         (i_data),
      .bus_grant      (bus_grant),
      .halt           (halt),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .IFIDWrite      (IFIDWrite),
      .IF_valid       (IF_valid),
      .IF_instr       (IF_instr),
      .IF_current_pc  (IF_current_pc),
      .IF_PC_plus_one (IF_PC_plus_one)
   );

   always #5 clk = ~clk;

   // Memory: acks a request after wait_states idle cycles; drives at negedge
   always @(negedge clk) begin
      if (!i_req) begin
         i_ack    = 1'b0;
         mem_wait = 0;
      end else begin
         if (i_ack) mem_wait = 0;
         if (mem_wait == 0) req_addr = i_addr;
         i_ack  = (mem_wait == wait_states);
         i_data = req_addr ^ 16'hA5A5;
         if (!i_ack) mem_wait = mem_wait + 1;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset with random inputs ----------------
      reset_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus_grant   = 1'($urandom);
         halt        = 1'($urandom);
         redirect    = 1'($urandom);
         redirect_pc = 16'($urandom);
         IFIDWrite   = 1'($urandom);
         step();
         check_value("rst_i_req", i_req, 0);
         check_value("rst_i_addr", i_addr, 16'h0000);
         check_value("rst_valid", IF_valid, 0);
      end
      check_value("rst_instr", IF_instr, 0);
      check_value("rst_pc", IF_current_pc, 0);
      check_value("rst_pc1", IF_PC_plus_one, 0);

      // ---------------- zero-wait streaming ----------------
      bus_grant   = 1'b1;
      halt        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      IFIDWrite   = 1'b1;
      wait_states = 0;
      reset_n     = 1'b1;
      step();
      check_value("first_req", i_req, 1);
      check_value("first_addr", i_addr, 16'h0000);
      check_value("first_valid", IF_valid, 0);
      for (int k = 0; k < 6; k++) begin
         step();
         check_value("stream_valid", IF_valid, 1);
         check_value("stream_pc", IF_current_pc, 16'(k));
         check_value("stream_pc1", IF_PC_plus_one, 16'(k + 1));
         check_value("stream_instr", IF_instr, 16'(k) ^ 16'hA5A5);
         check_value("stream_addr", i_addr, 16'(k + 1));
      end

      // ---------------- back-pressure ----------------
      redirect    = 1'b1;
      redirect_pc = 16'h0000;
      IFIDWrite   = 1'b0;
      step();
      check_value("bp_flush_valid", IF_valid, 0);
      check_value("bp_flush_req", i_req, 0);
      check_value("bp_flush_addr", i_addr, 16'h0000);
      redirect = 1'b0;
      step();
      check_value("bp_req0", i_addr, 16'h0000);
      step();
      check_value("bp_req1", i_addr, 16'h0001);
      step();
      check_value("bp_full_req", i_req, 0);
      check_value("bp_full_head", IF_current_pc, 16'h0000);
      repeat (3) step();
      check_value("bp_hold_req", i_req, 0);
      check_value("bp_hold_valid", IF_valid, 1);
      IFIDWrite = 1'b1;
      step();
      IFIDWrite = 1'b0;
      check_value("bp_one_req", i_req, 1);
      check_value("bp_one_addr", i_addr, 16'h0002);
      check_value("bp_one_head", IF_current_pc, 16'h0001);
      step();
      check_value("bp_refull_req", i_req, 0);
      check_value("bp_refull_head", IF_current_pc, 16'h0001);

      // ---------------- redirect in flight, 3-wait memory ----------------
      wait_states = 3;
      IFIDWrite   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 16'h0005;
      step();
      redirect = 1'b0;
      check_value("rd_flush_valid", IF_valid, 0);
      check_value("rd_flush_addr", i_addr, 16'h0005);
      step();
      check_value("rd_req5", i_req, 1);
      check_value("rd_addr5", i_addr, 16'h0005);
      step();
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      step();
      redirect = 1'b0;
      check_value("rd_discard_req", i_req, 1);
      check_value("rd_discard_valid", IF_valid, 0);
      check_value("rd_discard_addr", i_addr, 16'h0040);
      step();
      check_value("rd_discard2_req", i_req, 1);
      step();
      check_value("rd_drop_req", i_req, 0);
      check_value("rd_drop_valid", IF_valid, 0);
      step();
      check_value("rd_new_req", i_req, 1);
      check_value("rd_new_addr", i_addr, 16'h0040);
      for (int k = 0; k < 20 && !IF_valid; k++) step();
      check_value("rd_new_valid", IF_valid, 1);
      check_value("rd_new_pc", IF_current_pc, 16'h0040);
      check_value("rd_new_instr", IF_instr, 16'h0040 ^ 16'hA5A5);

      // ---------------- DMA contention ----------------
      bus_grant   = 1'b0;
      IFIDWrite   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 16'h0100;
      step();
      redirect = 1'b0;
      for (int k = 0; k < 20 && i_req; k++) step();
      check_value("dma_idle_req", i_req, 0);
      check_value("dma_idle_addr", i_addr, 16'h0100);
      repeat (3) step();
      check_value("dma_nogrant_req", i_req, 0);
      bus_grant = 1'b1;
      step();
      bus_grant = 1'b0;
      check_value("dma_start_req", i_req, 1);
      check_value("dma_start_addr", i_addr, 16'h0100);
      step();
      check_value("dma_hold1_req", i_req, 1);
      step();
      check_value("dma_hold2_req", i_req, 1);
      check_value("dma_hold2_addr", i_addr, 16'h0100);
      step();
      step();
      check_value("dma_done_req", i_req, 0);
      check_value("dma_done_valid", IF_valid, 1);
      check_value("dma_done_pc", IF_current_pc, 16'h0100);
      check_value("dma_done_instr", IF_instr, 16'hA4A5);
      check_value("dma_done_addr", i_addr, 16'h0101);
      repeat (2) step();
      check_value("dma_wait_req", i_req, 0);
      bus_grant = 1'b1;
      step();
      check_value("dma_regrant_req", i_req, 1);
      check_value("dma_regrant_addr", i_addr, 16'h0101);

      // ---------------- wrap and halt ----------------
      wait_states = 0;
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      step();
      redirect  = 1'b0;
      IFIDWrite = 1'b1;
      check_value("wrap_flush_req", i_req, 0);
      check_value("wrap_flush_valid", IF_valid, 0);
      step();
      check_value("wrap_req_addr", i_addr, 16'hFFFF);
      step();
      check_value("wrap_pc", IF_current_pc, 16'hFFFF);
      check_value("wrap_pc1", IF_PC_plus_one, 16'h0000);
      check_value("wrap_instr", IF_instr, 16'h5A5A);
      check_value("wrap_next_addr", i_addr, 16'h0000);
      halt = 1'b1;
      step();
      check_value("halt_req", i_req, 0);
      check_value("halt_valid", IF_valid, 1);
      check_value("halt_pc", IF_current_pc, 16'h0000);
      check_value("halt_pc1", IF_PC_plus_one, 16'h0001);
      check_value("halt_instr", IF_instr, 16'hA5A5);
      check_value("halt_addr", i_addr, 16'h0001);
      step();
      check_value("halt_drain_valid", IF_valid, 0);
      check_value("halt_drain_instr", IF_instr, 0);
      step();
      check_value("halt_idle_req", i_req, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
